// File: rtl/phase_seq_pkg.sv
// Shared opcodes and FSM state type for the phase frame sequencer.
package phase_seq_pkg;

  localparam logic [7:0] OP_SET    = 8'hFE;
  localparam logic [7:0] OP_COMMIT = 8'hFD;
  localparam logic [7:0] OP_CLEAR  = 8'hFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_CH = 2'd1,
    GET_PH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/phase_bank.sv
// Shadow and active phase register banks; the commit strobe copies every shadow
// channel into the active bank on the same edge.
module phase_bank #(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_W      = 8,
  parameter int CH_W         = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [CH_W-1:0]                 wr_ch,
  input  logic [PHASE_W-1:0]              wr_data,
  input  logic                            clr,
  input  logic                            commit,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phases
);

  logic [PHASE_W-1:0] shadow [NUM_CHANNELS];
  logic [PHASE_W-1:0] active [NUM_CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) shadow[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < NUM_CHANNELS; k++) shadow[k] <= '0;
    end else if (wr_en) begin
      shadow[wr_ch] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) active[k] <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_CHANNELS; k++) active[k] <= shadow[k];
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
    assign phases[g*PHASE_W +: PHASE_W] = active[g];
  end

endmodule

// File: rtl/phase_frame_sequencer.sv
// Opcode parser feeding a shadow phase bank with atomic commit on carrier-period ticks.
// Optional mid-packet idle timeout is enabled by defining PHASE_SEQ_TIMEOUT_EN.
module phase_frame_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int PHASE_W        = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic                            rx_ready,
  input  logic                            period_tick,
  input  logic                            err_clr,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phases_o,
  output logic                            commit_done,
  output logic                            busy,
  output logic                            read_error,
  output seq_state_t                      state_dbg
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // Handshake: a byte transfers on any edge where rx_valid & rx_ready; rx_ready
  // depends only on commit_pending, never on rx_valid.
  seq_state_t      state, state_nx;
  logic            accept;
  logic            commit_pending;
  logic            commit_fire;
  logic            drop;
  logic [CH_W-1:0] ch_q;
  logic            idx_bad;
  logic            timeout_hit;
  logic            pend_set, bank_clr, shadow_wr, ch_load, err_set;

  assign rx_ready    = ~commit_pending;
  assign accept      = rx_valid & rx_ready;
  assign idx_bad     = ({24'd0, rx_data} >= NUM_CHANNELS);
  assign commit_fire = period_tick & commit_pending;
  assign busy        = (state != IDLE) | commit_pending;
  assign state_dbg   = state;

`ifdef PHASE_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                   to_cnt <= '0;
    else if (state == IDLE || accept) to_cnt <= '0;
    else                              to_cnt <= to_cnt + 16'd1;
  end

  assign timeout_hit = (state != IDLE) && !accept && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && rx_data == OP_SET) state_nx = GET_CH;
      GET_CH:  if (timeout_hit) state_nx = IDLE;
               else if (accept) state_nx = GET_PH;
      GET_PH:  if (timeout_hit || accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pend_set  = 1'b0;
    bank_clr  = 1'b0;
    shadow_wr = 1'b0;
    ch_load   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (rx_data)
            OP_SET:    ;
            OP_COMMIT: pend_set = 1'b1;
            OP_CLEAR:  bank_clr = 1'b1;
            default:   err_set  = 1'b1;
          endcase
        end
      end
      GET_CH: begin
        if (accept) begin
          ch_load = 1'b1;
          err_set = idx_bad;
        end
      end
      GET_PH:  shadow_wr = accept & ~drop;
      default: ;
    endcase
    if (timeout_hit) err_set = 1'b1;
  end

  // A COMMIT accepted on a tick edge sees commit_pending=0, so that tick is skipped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      read_error     <= 1'b0;
      ch_q           <= '0;
      drop           <= 1'b0;
    end else begin
      if (pend_set)         commit_pending <= 1'b1;
      else if (commit_fire) commit_pending <= 1'b0;
      commit_done <= commit_fire;
      if (err_set)      read_error <= 1'b1;
      else if (err_clr) read_error <= 1'b0;
      if (ch_load) begin
        ch_q <= rx_data[CH_W-1:0];
        drop <= idx_bad;
      end
    end
  end

  phase_bank #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .PHASE_W     (PHASE_W),
    .CH_W        (CH_W)
  ) u_bank (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_en  (shadow_wr),
    .wr_ch  (ch_q),
    .wr_data(rx_data[PHASE_W-1:0]),
    .clr    (bank_clr),
    .commit (commit_fire),
    .phases (phases_o)
  );

endmodule
